// File: rtl/arb4_sched_spec.sv
// Four-requester bus scheduler monitor: ownership FSM, starvation bounding, and a sticky violation flag.
// All outputs are registered; a violation in cycle t shows on o_err at edge t+1. There is no backpressure, so every cycle is evaluated.
module arb4_sched_spec #(
    parameter int STARVE_MAX = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_ready,
    input  logic       i_release,
    input  logic [3:0] controllable_grant,
    input  logic [1:0] controllable_master,
    output logic       o_err,
    output logic       o_busy,
    output logic [1:0] o_owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        BUSY    = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t          state;
    logic [3:0]      pending;
    logic [3:0][2:0] starve;

    logic       idle;
    logic       grant_any;
    logic [3:0] granted;
    logic [1:0] grant_idx;
    logic       multi_grant;
    logic [3:0] unrequested;
    logic [3:0] starved;
    logic       viol;

    always_comb begin
        idle      = (state == IDLE);
        grant_any = |controllable_grant;
        // Only a grant issued from IDLE actually hands the bus over.
        granted   = idle ? controllable_grant : 4'b0000;

        grant_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (controllable_grant[i]) grant_idx = 2'(i);
        end

        multi_grant = (controllable_grant & (controllable_grant - 4'd1)) != 4'b0000;
        unrequested = controllable_grant & ~(pending | i_req);

        starved = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            starved[i] = (starve[i] == STARVE_LIM);
        end

        viol = multi_grant
             | (|unrequested)
             | (grant_any & ~i_ready)
             | (grant_any & ~idle)
             | (~idle & (controllable_master != o_owner))
             | (|starved);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_err   <= 1'b0;
            o_busy  <= 1'b0;
            o_owner <= 2'd0;
            pending <= 4'b0000;
            starve  <= '0;
        end else begin
            o_err <= o_err | viol;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state   <= GRANTED;
                        o_busy  <= 1'b1;
                        o_owner <= grant_idx;
                    end
                end
                GRANTED: begin
                    state  <= BUSY;
                    o_busy <= 1'b1;
                end
                BUSY: begin
                    if (i_release) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            for (int i = 0; i < 4; i++) begin
                pending[i] <= granted[i] ? 1'b0 : (pending[i] | i_req[i]);
                // A busy bus or a not-ready environment holds the count rather than charging it.
                if (granted[i] || !pending[i]) begin
                    starve[i] <= 3'd0;
                end else if (idle && i_ready && (starve[i] != 3'd7)) begin
                    starve[i] <= starve[i] + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arb4_sched_spec.sv
// Scoreboard bench for arb4_sched_spec: each driven cycle pushes its expected post-edge outputs, popped after the edge.
module tb_arb4_sched_spec;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [3:0] i_req;
    logic       i_ready;
    logic       i_release;
    logic [3:0] controllable_grant;
    logic [1:0] controllable_master;
    logic       o_err;
    logic       o_busy;
    logic [1:0] o_owner;

    arb4_sched_spec #(.STARVE_MAX(3)) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_req               (i_req),
        .i_ready             (i_ready),
        .i_release           (i_release),
        .controllable_grant  (controllable_grant),
        .controllable_master (controllable_master),
        .o_err               (o_err),
        .o_busy              (o_busy),
        .o_owner             (o_owner)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       err;
        logic       busy;
        logic [1:0] owner;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tname  = "";

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", tname, tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after its edge, then compare.
    task automatic cyc(input int rst, input int req, input int rdy, input int rel,
                       input int gnt, input int mst,
                       input int e_err, input int e_busy, input int e_own);
        exp_t e;
        exp_t got;
        i_rst               = 1'(rst);
        i_req               = 4'(req);
        i_ready             = 1'(rdy);
        i_release           = 1'(rel);
        controllable_grant  = 4'(gnt);
        controllable_master = 2'(mst);
        e.err   = 1'(e_err);
        e.busy  = 1'(e_busy);
        e.owner = 2'(e_own);
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            got = sb.pop_front();
            chk("err",   int'(o_err),   int'(got.err));
            chk("busy",  int'(o_busy),  int'(got.busy));
            chk("owner", int'(o_owner), int'(got.owner));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_req = 4'h0; i_ready = 1'b0; i_release = 1'b0;
        controllable_grant = 4'h0; controllable_master = 2'd0;

        // rst req rdy rel gnt mst | err busy owner
        tname = "idle";
        cyc(1, 0, 0, 0, 0, 0,  0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 0,  0, 0, 0);

        tname = "legal";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0100,  1, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0100,  1, 0, 'b0100,  0,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       2,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       2,  0, 1, 2);
        cyc(0, 0,       1, 1, 0,       2,  0, 0, 2);
        cyc(0, 0,       1, 0, 0,       0,  0, 0, 2);
        chk("pending", int'(dut.pending), 0);

        tname = "master";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0100,  1, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0100,  1, 0, 'b0100,  0,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       2,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       1,  1, 1, 2);
        cyc(0, 0,       1, 1, 0,       2,  1, 0, 2);
        cyc(0, 0,       1, 0, 0,       0,  1, 0, 2);

        tname = "v1";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0011,  1, 0, 'b0011,  0,  1, 1, 0);
        cyc(0, 0,       1, 0, 0,       0,  1, 1, 0);

        tname = "v2";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 0,       1, 0, 'b1000,  3,  1, 1, 3);

        tname = "v3";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  0, 0, 'b0001,  0,  1, 1, 0);

        tname = "v4";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  1, 0, 'b0001,  0,  0, 1, 0);
        cyc(0, 0,       1, 0, 0,       0,  0, 1, 0);
        cyc(0, 'b0010,  1, 1, 'b0010,  0,  1, 0, 0);
        cyc(0, 0,       0, 0, 0,       0,  1, 0, 0);

        tname = "starve";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        chk("cnt0", int'(dut.starve[0]), 0);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        chk("cnt1", int'(dut.starve[0]), 1);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        chk("cnt2", int'(dut.starve[0]), 2);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        chk("cnt3", int'(dut.starve[0]), 3);
        cyc(0, 'b0001,  1, 0, 0,       0,  1, 0, 0);

        tname = "starve_ok";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0001,  1, 0, 0,       0,  0, 0, 0);
        chk("cnt2", int'(dut.starve[0]), 2);
        cyc(0, 'b0001,  1, 0, 'b0001,  0,  0, 1, 0);
        chk("cnt_clr", int'(dut.starve[0]), 0);
        cyc(0, 0,       1, 0, 0,       0,  0, 1, 0);
        cyc(0, 0,       1, 1, 0,       0,  0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0, 0, 0,  0, 0, 0);

        tname = "rst_mid";
        cyc(1, 0,       0, 0, 0,       0,  0, 0, 0);
        cyc(0, 'b0100,  1, 0, 'b0100,  0,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       1,  1, 1, 2);
        cyc(0, 'b0001,  1, 0, 0,       2,  1, 1, 2);
        chk("pend_set", int'(dut.pending), 'b0001);
        cyc(1, 'b0001,  1, 0, 0,       2,  0, 0, 0);
        chk("pend_clr", int'(dut.pending), 0);
        cyc(0, 'b0100,  1, 0, 'b0100,  0,  0, 1, 2);
        cyc(0, 0,       1, 0, 0,       2,  0, 1, 2);
        cyc(0, 0,       1, 1, 0,       2,  0, 0, 2);
        cyc(0, 0,       1, 0, 0,       0,  0, 0, 2);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb4_sched_spec.md
# arb4_sched_spec

Four-requester shared-bus scheduler specification monitor for reactive-synthesis benchmarks. The environment drives requests, readiness and bus release. The synthesized controller drives the grant vector and the master select through `controllable_*` inputs. The block tracks ownership with a three-state FSM, bounds per-requester starvation, and raises a sticky `o_err` on any safety or fairness violation. It extends the single-pair grant/master property to a sequenced, multi-requester bus with a release handshake.

## Interface
- `STARVE_MAX`, default 3: cycles a pending requester may be passed over while the bus is grantable; legal range 1..7.
- `i_clk`  in  1  rising-edge clock, sole clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  4  environment request per requester; level-sensitive.
- `i_ready`  in  1  environment: bus may be granted this cycle.
- `i_release`  in  1  environment: current owner releases bus this cycle.
- `controllable_grant`  in  4  controller: grant vector.
- `controllable_master`  in  2  controller: index of bus master.
- `o_err`  out  1  sticky violation flag, registered.
- `o_busy`  out  1  FSM not IDLE, registered.
- `o_owner`  out  2  index of current owner, registered; meaningful only when `o_busy`=1.

## Operation
- Reset (`i_rst`=1 at a clock edge):
  - state=IDLE; `o_err`=0; `o_busy`=0; `o_owner`=0.
  - `pending`=0; all starvation counters=0.
  - Reset overrides every other event in the same cycle.
- `pending[i]`:
  - Set in any cycle where `i_req[i]`=1.
  - Cleared on the edge where requester i is granted (IDLE→GRANTED).
  - Set takes priority only when the requester is not being granted in that cycle.
- A grant is legal for requester i when `pending[i] | i_req[i]`.
- FSM:
  - IDLE: if `controllable_grant`≠0, go to GRANTED and latch `o_owner` = index of the set bit. Otherwise stay.
  - GRANTED: go to BUSY unconditionally after 1 cycle.
  - BUSY: if `i_release`=1, go to IDLE. Otherwise stay.
- Violations, evaluated combinationally each cycle from current state and inputs:
  - V1: `controllable_grant` has more than one bit set.
  - V2: a grant bit is set for requester i with no legal request.
  - V3: `controllable_grant`≠0 while `i_ready`=0.
  - V4: `controllable_grant`≠0 while state≠IDLE. This includes BUSY with `i_release`=1 in the same cycle; release takes effect next cycle.
  - V5: state is GRANTED or BUSY and `controllable_master`≠`o_owner`.
  - V6: any starvation counter equals `STARVE_MAX`.
- When V1 fires, the FSM still transitions and latches the lowest-index set bit as owner. This keeps the model deterministic; `o_err` is set regardless.
- Starvation counter per requester, 3 bits, saturating at 7:
  - Cleared when requester i is granted or `pending[i]`=0.
  - Incremented when `pending[i]`=1, state=IDLE, `i_ready`=1, and i is not granted this cycle.
  - Held otherwise. A busy bus or a not-ready environment is not the controller's fault.
- `o_err` <= `o_err` | V1 | V2 | V3 | V4 | V5 | V6. Cleared only by reset.
- `o_busy` <= (next state ≠ IDLE).

## Timing
- All outputs are registered. A violation in cycle t appears on `o_err` at edge t+1.
- Grant in cycle t (IDLE): `o_busy`=1 and `o_owner` valid from edge t+1. Master must match from cycle t+1 on (GRANTED), then throughout BUSY.
- Minimum ownership is 2 cycles (GRANTED + one BUSY cycle). The earliest `i_release` honoured is in the first BUSY cycle, and `o_busy`=0 follows at the next edge.
- Back-to-back: earliest new grant is the cycle after the releasing edge (state IDLE).
- Starvation: with `STARVE_MAX`=3, a requester passed over in 3 grantable cycles produces V6 in the cycle where its counter reads 3, and `o_err` one edge later.
- `i_rst` asserted mid-BUSY: the next edge returns to IDLE and drops all pending state and counters.

## Test plan
- Reset then idle: `i_rst`=1 for 1 cycle, all inputs 0 for 10 cycles → `o_err`=0, `o_busy`=0, `o_owner`=0 throughout.
- Legal transaction:
  - Stimulus: `i_req`=0b0100, `i_ready`=1, grant=0b0100 at cycle 2, master=2 from cycle 3, `i_release` at cycle 5.
  - Response: `o_busy`=1 cycles 3–5, `o_owner`=2, IDLE at edge 6, `o_err`=0.
- Master mismatch: same as the legal transaction but master=1 at cycle 4 → `o_err`=1 from edge 5 and stays 1 after the transaction ends.
- Illegal grants, each run from reset with `o_err`=1 one edge later:
  - grant=0b0011 with both requesting (V1).
  - grant=0b1000 with `i_req`=0 (V2).
  - grant while `i_ready`=0 (V3).
  - grant during BUSY (V4).
- Starvation: `STARVE_MAX`=3, `i_req`=0b0001 held, `i_ready`=1, controller never grants → counter reads 1, 2, 3; `o_err` rises exactly 1 edge after the counter reaches 3. Granting at the cycle the counter reads 2 keeps `o_err`=0.
- Reset mid-operation: assert `i_rst` during BUSY with `o_err`=1 → next edge `o_err`=0, `o_busy`=0, `pending`=0; a following legal transaction completes error-free.
